if_fetch_icache: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the memory allocator.
- Holds the PC and a direct-mapped, one-word-per-line instruction cache.
- On a hit it delivers one instruction per cycle to the decoder.
- On a miss it issues a 4-byte read request to the allocator, fills the cache line, then retries. It redirects on clear_branch_in.

---
 rtl/if_fetch_icache_if.sv | 25 ++
 rtl/if_fetch_icache.sv | 118 +++++++++++
 tb/tb_if_fetch_icache.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_icache_if.sv
// rtl/if_fetch_icache_if.sv - fetch stage allocator-side and decoder-side signal bundle
interface if_fetch_icache_if;
    logic        if_to_alloc_en_out;
    logic [31:0] if_a_out;
    logic [1:0]  if_offset_out;
    logic        alloc_to_if_gr_in;
    logic        alloc_to_if_en_in;
    logic [31:0] if_d_in;
    logic        stall_in;
    logic        if_to_dec_en_out;
    logic [31:0] if_pc_out;
    logic [31:0] if_instr_out;

    modport master (
        output if_to_alloc_en_out, if_a_out, if_offset_out,
        output if_to_dec_en_out, if_pc_out, if_instr_out,
        input  alloc_to_if_gr_in, alloc_to_if_en_in, if_d_in, stall_in
    );

    modport slave (
        input  if_to_alloc_en_out, if_a_out, if_offset_out,
        input  if_to_dec_en_out, if_pc_out, if_instr_out,
        output alloc_to_if_gr_in, alloc_to_if_en_in, if_d_in, stall_in
    );
endinterface

// File: rtl/if_fetch_icache.sv
// rtl/if_fetch_icache.sv - instruction fetch with direct-mapped one-word-per-line icache
module if_fetch_icache #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_branch_in,
    input  logic [31:0]       branch_pc_in,
    if_fetch_icache_if.master bus
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic [31:0]             a_q, a_d;
    logic                    dec_en_q, dec_en_d;
    logic [31:0]             dec_pc_q, dec_pc_d;
    logic [31:0]             dec_instr_q, dec_instr_d;
    logic [LINES-1:0]        valid_q;
    logic [31:0]             data_mem [LINES];
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [ICACHE_IDX_W-1:0] idx;
    logic [TAG_W-1:0]        pc_tag;
    logic                    hit;
    logic                    fill;

    // pc never moves while a miss is outstanding, so it also addresses the refill
    assign idx    = pc_q[ICACHE_IDX_W+1:2];
    assign pc_tag = pc_q[31:ICACHE_IDX_W+2];
    assign hit    = valid_q[idx] && (tag_mem[idx] == pc_tag);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            a_q         <= 32'h0;
            dec_en_q    <= 1'b0;
            dec_pc_q    <= 32'h0;
            dec_instr_q <= 32'h0;
            valid_q     <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            dec_en_q    <= dec_en_d;
            dec_pc_q    <= dec_pc_d;
            dec_instr_q <= dec_instr_d;
            if (fill) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill) begin
            data_mem[idx] <= bus.if_d_in;
            tag_mem[idx]  <= pc_tag;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_branch_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (!hit) state_d = S_REQ;
                S_REQ:   if (bus.alloc_to_if_gr_in) state_d = S_WAIT;
                S_WAIT:  if (bus.alloc_to_if_en_in) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d        = pc_q;
        a_d         = a_q;
        dec_en_d    = 1'b0;
        dec_pc_d    = dec_pc_q;
        dec_instr_d = dec_instr_q;
        fill        = 1'b0;
        if (clear_branch_in) begin
            pc_d = branch_pc_in;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // a miss is raised even while the decoder stalls
                    if (!hit) begin
                        a_d = pc_q;
                    end else if (!bus.stall_in) begin
                        dec_en_d    = 1'b1;
                        dec_pc_d    = pc_q;
                        dec_instr_d = data_mem[idx];
                        pc_d        = pc_q + 32'd4;
                    end
                end
                S_WAIT:  fill = bus.alloc_to_if_en_in;
                default: fill = 1'b0;
            endcase
        end
    end

    assign bus.if_to_alloc_en_out = (state_q == S_REQ);
    assign bus.if_a_out           = a_q;
    assign bus.if_offset_out      = 2'b11;
    assign bus.if_to_dec_en_out   = dec_en_q;
    assign bus.if_pc_out          = dec_pc_q;
    assign bus.if_instr_out       = dec_instr_q;
endmodule

// File: tb/tb_if_fetch_icache.sv
// tb/tb_if_fetch_icache.sv - randomized self-checking bench for if_fetch_icache
module tb_if_fetch_icache;
    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_branch_in;
    logic [31:0] branch_pc_in;

    if_fetch_icache_if bus ();

    if_fetch_icache #(.ICACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_branch_in (clear_branch_in),
        .branch_pc_in    (branch_pc_in),
        .bus             (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int          checks;
    int          errors;
    int          reqs;
    int          pulses;
    logic [31:0] exp_pc;
    logic [31:0] req_addr;
    logic [63:0] mvalid;
    logic [23:0] mtag [64];
    // 0 idle, 1 request raised, 2 waiting for data, 3 data driven, 4 flush driven
    int          alloc_st;
    int          gr_delay_left;
    int          gr_left;
    int          lat_left;
    bit          granted;
    bit          exp_pulse;
    bit          exp_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit mhit(input logic [31:0] a);
        return mvalid[a[7:2]] && (mtag[a[7:2]] == a[31:8]);
    endfunction

    task automatic tick(input bit stall_v, input int gr_delay, input int gr_hold, input int lat);
        @(negedge clk_in);
        checks++;
        if (bus.if_to_dec_en_out !== exp_pulse) begin
            errors++;
            $display("FAIL dec_pulse pc=%h got %b want %b", exp_pc, bus.if_to_dec_en_out, exp_pulse);
        end
        if (bus.if_to_dec_en_out === 1'b1) begin
            checks += 2;
            if (bus.if_pc_out !== exp_pc) begin
                errors++;
                $display("FAIL dec_pc got %h want %h", bus.if_pc_out, exp_pc);
            end
            if (bus.if_instr_out !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL dec_instr pc=%h got %h want %h", exp_pc, bus.if_instr_out, mem_word(exp_pc));
            end
            exp_pc += 32'd4;
            pulses++;
        end
        case (alloc_st)
            0: begin
                checks++;
                if (bus.if_to_alloc_en_out !== exp_req) begin
                    errors++;
                    $display("FAIL req_raise pc=%h got %b want %b", exp_pc, bus.if_to_alloc_en_out, exp_req);
                end
                if (bus.if_to_alloc_en_out === 1'b1) begin
                    checks += 2;
                    if (bus.if_a_out !== exp_pc) begin
                        errors++;
                        $display("FAIL req_addr got %h want %h", bus.if_a_out, exp_pc);
                    end
                    if (bus.if_offset_out !== 2'b11) begin
                        errors++;
                        $display("FAIL req_offset got %0d want 3", bus.if_offset_out);
                    end
                    req_addr      = bus.if_a_out;
                    alloc_st      = 1;
                    gr_delay_left = gr_delay;
                    granted       = 1'b0;
                    reqs++;
                end
            end
            1: begin
                checks += 2;
                if (bus.if_to_alloc_en_out !== !granted) begin
                    errors++;
                    $display("FAIL req_hold got %b want %b", bus.if_to_alloc_en_out, !granted);
                end
                if (bus.if_a_out !== req_addr) begin
                    errors++;
                    $display("FAIL req_addr_hold got %h want %h", bus.if_a_out, req_addr);
                end
                if (granted) begin
                    alloc_st = 2;
                    gr_left  = gr_hold - 1;
                    lat_left = lat;
                    granted  = 1'b0;
                end
            end
            2, 3: begin
                checks += 3;
                if (bus.if_to_alloc_en_out !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_no_req got %b want 0", bus.if_to_alloc_en_out);
                end
                if (bus.if_a_out !== req_addr) begin
                    errors++;
                    $display("FAIL wait_addr got %h want %h", bus.if_a_out, req_addr);
                end
                if (bus.if_offset_out !== 2'b11) begin
                    errors++;
                    $display("FAIL wait_offset got %0d want 3", bus.if_offset_out);
                end
                if (alloc_st == 3) begin
                    mvalid[req_addr[7:2]] = 1'b1;
                    mtag[req_addr[7:2]]   = req_addr[31:8];
                    alloc_st = 0;
                end
            end
            default: begin
                checks++;
                if (bus.if_to_alloc_en_out !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_no_req got %b want 0", bus.if_to_alloc_en_out);
                end
                alloc_st = 0;
            end
        endcase
        clear_branch_in       = 1'b0;
        rdy_in                = 1'b1;
        bus.alloc_to_if_gr_in = 1'b0;
        bus.alloc_to_if_en_in = 1'b0;
        bus.if_d_in           = $urandom;
        bus.stall_in          = stall_v;
        if (alloc_st == 1) begin
            if (gr_delay_left > 0) gr_delay_left--;
            else begin
                bus.alloc_to_if_gr_in = 1'b1;
                granted = 1'b1;
            end
        end else if (alloc_st == 2) begin
            if (gr_left > 0) begin
                bus.alloc_to_if_gr_in = 1'b1;
                gr_left--;
            end
            if (lat_left > 0) lat_left--;
            else begin
                bus.alloc_to_if_en_in = 1'b1;
                bus.if_d_in           = mem_word(req_addr);
                alloc_st              = 3;
            end
        end
        exp_pulse = (alloc_st == 0) && mhit(exp_pc) && !stall_v;
        exp_req   = (alloc_st == 0) && !mhit(exp_pc);
    endtask

    // overrides the inputs already queued for the next edge with a flush
    task automatic redirect(input logic [31:0] target, input bit with_data);
        clear_branch_in       = 1'b1;
        branch_pc_in          = target;
        bus.alloc_to_if_gr_in = 1'b0;
        bus.alloc_to_if_en_in = with_data;
        bus.if_d_in           = ~mem_word(req_addr);
        exp_pc                = target;
        alloc_st              = 4;
        granted               = 1'b0;
        exp_pulse             = 1'b0;
        exp_req               = 1'b0;
    endtask

    task automatic run_until(input logic [31:0] target, input int gd, input int gh, input int lat);
        for (int i = 0; i < 300 && exp_pc != target; i++) tick(1'b0, gd, gh, lat);
        checks++;
        if (exp_pc !== target) begin
            errors++;
            $display("FAIL run_timeout got %h want %h", exp_pc, target);
        end
    endtask

    task automatic wait_for_wait_state(input int lat);
        for (int i = 0; i < 50 && alloc_st != 2; i++) tick(1'b0, 0, 1, lat);
        checks++;
        if (alloc_st != 2) begin
            errors++;
            $display("FAIL wait_timeout got %0d want 2", alloc_st);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_in = 1'b1; rdy_in = 1'b1; clear_branch_in = 1'b0; branch_pc_in = 32'h0;
        bus.stall_in = 1'b0; bus.alloc_to_if_gr_in = 1'b0; bus.alloc_to_if_en_in = 1'b0;
        bus.if_d_in = 32'h0;
        repeat (3) @(negedge clk_in);
        checks += 6;
        if (bus.if_to_alloc_en_out !== 1'b0) begin errors++; $display("FAIL rst_alloc_en got %b want 0", bus.if_to_alloc_en_out); end
        if (bus.if_to_dec_en_out !== 1'b0) begin errors++; $display("FAIL rst_dec_en got %b want 0", bus.if_to_dec_en_out); end
        if (bus.if_a_out !== 32'h0) begin errors++; $display("FAIL rst_a got %h want 0", bus.if_a_out); end
        if (bus.if_pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", bus.if_pc_out); end
        if (bus.if_instr_out !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", bus.if_instr_out); end
        if (bus.if_offset_out !== 2'b11) begin errors++; $display("FAIL rst_offset got %0d want 3", bus.if_offset_out); end
        rst_in = 1'b0;
        exp_pc = 32'h0; mvalid = '0; alloc_st = 0; granted = 1'b0;
        exp_pulse = 1'b0; exp_req = 1'b1;
    endtask

    task automatic test_cold_start();
        int r0;
        r0 = reqs;
        run_until(32'h4, 0, 1, 0);
        checks++;
        if (reqs - r0 !== 1) begin errors++; $display("FAIL cold_reqs got %0d want 1", reqs - r0); end
    endtask

    task automatic test_back_to_back();
        int r0, p0;
        run_until(32'h10, 1, 2, 1);
        redirect(32'h0, 1'b0);
        tick(1'b0, 0, 1, 0);
        r0 = reqs; p0 = pulses;
        repeat (4) tick(1'b0, 0, 1, 0);
        checks += 2;
        if (pulses - p0 !== 4) begin errors++; $display("FAIL b2b_pulses got %0d want 4", pulses - p0); end
        if (reqs - r0 !== 0) begin errors++; $display("FAIL b2b_reqs got %0d want 0", reqs - r0); end
    endtask

    task automatic test_stall();
        int p0;
        redirect(32'h4, 1'b0);
        tick(1'b1, 0, 1, 0);
        p0 = pulses;
        repeat (3) tick(1'b1, 0, 1, 0);
        tick(1'b0, 0, 1, 0);
        checks += 2;
        if (pulses - p0 !== 0) begin errors++; $display("FAIL stall_pulses got %0d want 0", pulses - p0); end
        if (exp_pc !== 32'h4) begin errors++; $display("FAIL stall_pc got %h want 4", exp_pc); end
        tick(1'b0, 0, 1, 0);
        checks++;
        if (exp_pc !== 32'h8) begin errors++; $display("FAIL stall_release got %h want 8", exp_pc); end
    endtask

    task automatic test_grant_hold();
        int r0;
        redirect(32'h40, 1'b0);
        r0 = reqs;
        run_until(32'h44, 0, 5, 4);
        checks++;
        if (reqs - r0 !== 1) begin errors++; $display("FAIL grant_hold_reqs got %0d want 1", reqs - r0); end
    endtask

    task automatic test_clear_in_wait();
        int r0;
        redirect(32'h200, 1'b0);
        r0 = reqs;
        wait_for_wait_state(5);
        redirect(32'h100, 1'b1);
        run_until(32'h104, 0, 1, 1);
        redirect(32'h200, 1'b0);
        run_until(32'h204, 0, 1, 1);
        checks++;
        if (reqs - r0 !== 3) begin errors++; $display("FAIL clear_reqs got %0d want 3", reqs - r0); end
    endtask

    task automatic test_alias();
        int r0;
        redirect(32'h0, 1'b0);
        run_until(32'h4, 0, 1, 0);
        r0 = reqs;
        redirect(32'h100, 1'b0);
        run_until(32'h104, 0, 1, 0);
        checks++;
        if (reqs - r0 !== 1) begin errors++; $display("FAIL alias_fill got %0d want 1", reqs - r0); end
        redirect(32'h0, 1'b0);
        run_until(32'h4, 0, 1, 0);
        checks++;
        if (reqs - r0 !== 2) begin errors++; $display("FAIL alias_return got %0d want 2", reqs - r0); end
    endtask

    task automatic test_rdy_freeze();
        redirect(32'h300, 1'b0);
        wait_for_wait_state(4);
        rdy_in = 1'b0;
        bus.alloc_to_if_gr_in = 1'b0;
        bus.alloc_to_if_en_in = 1'b1;
        bus.if_d_in = ~mem_word(req_addr);
        @(negedge clk_in);
        checks += 2;
        if (bus.if_to_alloc_en_out !== 1'b0) begin errors++; $display("FAIL freeze_req got %b want 0", bus.if_to_alloc_en_out); end
        if (bus.if_a_out !== req_addr) begin errors++; $display("FAIL freeze_addr got %h want %h", bus.if_a_out, req_addr); end
        rdy_in = 1'b1;
        bus.alloc_to_if_en_in = 1'b0;
        run_until(32'h308, 0, 1, 1);
    endtask

    task automatic test_random();
        int p0;
        logic [31:0] tgt;
        p0 = pulses;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                tgt = 32'($urandom_range(0, 3)) << 8 | 32'($urandom_range(0, 15)) << 2;
                redirect(tgt, 1'($urandom_range(0, 1)));
            end
            tick($urandom_range(0, 9) < 3, $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 3));
        end
        checks++;
        if (pulses - p0 <= 0) begin errors++; $display("FAIL random_progress got %0d want >0", pulses - p0); end
    endtask

    initial begin
        checks = 0; errors = 0; reqs = 0; pulses = 0;
        req_addr = 32'h0; gr_delay_left = 0; gr_left = 0; lat_left = 0;
        test_reset();
        test_cold_start();
        test_back_to_back();
        test_stall();
        test_grant_hold();
        test_clear_in_wait();
        test_alias();
        test_rdy_freeze();
        test_random();
        test_reset();
        test_cold_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
